// File: rtl/tv80_regdump.sv
// Register-file dump engine: walks register-pair addresses and streams H/L bytes over a
// valid/ready handshake. Define TV80_REGDUMP_CKSUM_EN to append a zero-sum checksum byte.
module tv80_regdump #(
   parameter int unsigned NUM_REGS = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       abort,
   output logic [2:0] rf_addr,
   input  logic [7:0] rf_doh,
   input  logic [7:0] rf_dol,
   output logic [7:0] dump_data,
   output logic       dump_valid,
   input  logic       dump_ready,
   output logic       dump_last,
   output logic       busy,
   output logic       done
);

   localparam logic [2:0] LastIdx = 3'(NUM_REGS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StSendH,
      StSendL,
      StDone
`ifdef TV80_REGDUMP_CKSUM_EN
      , StSendCk
`endif
   } state_e;

   state_e     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] hold_h_q, hold_h_d;
   logic [7:0] hold_l_q, hold_l_d;
`ifdef TV80_REGDUMP_CKSUM_EN
   logic [7:0] cksum_q, cksum_d;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         idx_q    <= 3'd0;
         hold_h_q <= 8'd0;
         hold_l_q <= 8'd0;
`ifdef TV80_REGDUMP_CKSUM_EN
         cksum_q  <= 8'd0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         hold_h_q <= hold_h_d;
         hold_l_q <= hold_l_d;
`ifdef TV80_REGDUMP_CKSUM_EN
         cksum_q  <= cksum_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      hold_h_d   = hold_h_q;
      hold_l_d   = hold_l_q;
`ifdef TV80_REGDUMP_CKSUM_EN
      cksum_d    = cksum_q;
`endif
      dump_valid = 1'b0;
      dump_data  = 8'd0;
      dump_last  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start && !abort) begin
               idx_d   = 3'd0;
               state_d = StFetch;
`ifdef TV80_REGDUMP_CKSUM_EN
               cksum_d = 8'd0;
`endif
            end
         end
         StFetch: begin
            // Snapshot the pair so later register-file writes cannot disturb it.
            hold_h_d = rf_doh;
            hold_l_d = rf_dol;
            state_d  = StSendH;
         end
         StSendH: begin
            dump_valid = 1'b1;
            dump_data  = hold_h_q;
            if (dump_ready) begin
               state_d = StSendL;
`ifdef TV80_REGDUMP_CKSUM_EN
               cksum_d = cksum_q + hold_h_q;
`endif
            end
         end
         StSendL: begin
            dump_valid = 1'b1;
            dump_data  = hold_l_q;
`ifndef TV80_REGDUMP_CKSUM_EN
            dump_last  = (idx_q == LastIdx);
`endif
            if (dump_ready) begin
`ifdef TV80_REGDUMP_CKSUM_EN
               cksum_d = cksum_q + hold_l_q;
`endif
               if (idx_q == LastIdx) begin
`ifdef TV80_REGDUMP_CKSUM_EN
                  state_d = StSendCk;
`else
                  state_d = StDone;
`endif
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = StFetch;
               end
            end
         end
`ifdef TV80_REGDUMP_CKSUM_EN
         StSendCk: begin
            dump_valid = 1'b1;
            dump_data  = ~cksum_q + 8'd1;
            dump_last  = 1'b1;
            if (dump_ready) begin
               state_d = StDone;
            end
         end
`endif
         StDone: begin
            state_d = StIdle;
            idx_d   = 3'd0;
         end
         default: begin
            state_d = StIdle;
            idx_d   = 3'd0;
         end
      endcase

      // A transfer in the abort cycle still completes on the bus; the dump just stops.
      if (abort && (state_q != StIdle)) begin
         state_d = StIdle;
         idx_d   = 3'd0;
      end
   end

   assign rf_addr = idx_q;
   assign busy    = (state_q != StIdle);
   assign done    = (state_q == StDone);

endmodule
